// File: rtl/uart_pkg.sv
// Shared UART constants and the rts flow-control state encoding.
package uart_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {
    RTS_ON  = 1'b0,
    RTS_OFF = 1'b1
  } flow_state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W storage, one synchronous write port and one asynchronous read port, no reset.
// Latency: write visible on the read port after the writing edge; no backpressure (caller guards occupancy).
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with registered head byte (one extra cycle after push), sticky error flags and rts hysteresis.
// Full FIFO drops pushes unless a pop coincides; optional drop_count under UART_RX_FIFO_STATS_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int IN_EDGE   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_error,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     rts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     err_clr
`ifdef UART_RX_FIFO_STATS_EN
  ,output logic [15:0]             drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic              r_in_vld_d;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [BYTE_W-1:0] r_out_data, w_mem_rdata;
  logic              r_out_vld, r_overflow, r_frame_err;
  flow_state_t       r_state, w_state_nxt;
  logic              w_in_evt, w_push, w_err, w_pop, w_full, w_wr, w_drop, w_mem_avail, w_load;

  assign w_in_evt    = in_valid & ((IN_EDGE == 0) | ~r_in_vld_d);
  assign w_push      = w_in_evt & ~in_error;
  assign w_err       = w_in_evt & in_error;
  assign w_pop       = r_out_vld & out_ready;
  assign w_full      = (r_count == FULL_C);
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
  // count includes the byte held in the head register, so memory holds count - out_valid entries
  assign w_mem_avail = (r_count > {{AW{1'b0}}, r_out_vld});
  assign w_load      = w_mem_avail & (~r_out_vld | w_pop);

  uart_fifo_mem #(.DEPTH(DEPTH), .W(BYTE_W)) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_vld_d  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_in_vld_d <= in_valid;
      r_count    <= w_count_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_out_data <= w_mem_rdata;
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_out_vld  <= 1'b1;
      end else if (w_pop) begin
        r_out_vld  <= 1'b0;
      end
      if (w_drop)       r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_err)        r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RTS_ON;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RTS_ON:  if (w_count_nxt >= AF_C) w_state_nxt = RTS_OFF;
      RTS_OFF: if (w_count_nxt <= AE_C) w_state_nxt = RTS_ON;
    endcase
  end

  always_comb begin
    rts = (r_state == RTS_OFF);
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] r_drop_count;
  logic        w_drop_inc;

  assign w_drop_inc = w_drop | w_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   r_drop_count <= '0;
    else if (err_clr)                               r_drop_count <= {15'd0, w_drop_inc};
    else if (w_drop_inc && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end

  assign drop_count = r_drop_count;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_vld;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, compared against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH   = 16;
  localparam int AF      = 12;
  localparam int AE      = 4;
  localparam int IN_EDGE = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_error = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       rts;
  logic [4:0] count;
  logic       overflow;
  logic       frame_err;
  logic       err_clr = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_vld, m_prev, m_rts, m_ovf, m_ferr;
  int         m_drop;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .IN_EDGE(IN_EDGE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_error  (in_error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rts       (rts),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .err_clr   (err_clr)
`ifdef UART_RX_FIFO_STATS_EN
    ,.drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_vld = 0; m_prev = 0; m_rts = 0; m_ovf = 0; m_ferr = 0; m_drop = 0;
  endtask

  task automatic model_edge(input logic iv, input logic ie, input logic [7:0] d,
                            input logic rdy, input logic clr);
    int n;
    bit evt, push, err, pop, drop, inc;
    evt  = iv && (IN_EDGE == 0 || !m_prev);
    m_prev = iv;
    push = evt && !ie;
    err  = evt && ie;
    n    = q.size();
    pop  = m_vld && rdy;
    if (pop) void'(q.pop_front());
    drop = push && (n == DEPTH) && !pop;
    if (push && !drop) q.push_back(d);
    // a byte is shown one cycle after it was stored, so only pre-edge survivors count
    m_vld = (n - int'(pop)) > 0;
    if (!m_rts && q.size() >= AF)     m_rts = 1;
    else if (m_rts && q.size() <= AE) m_rts = 0;
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    if (err) m_ferr = 1; else if (clr) m_ferr = 0;
    inc = drop || err;
    if (clr)                         m_drop = inc ? 1 : 0;
    else if (inc && m_drop < 65535)  m_drop = m_drop + 1;
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("rts", 32'(rts), 32'(m_rts));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef UART_RX_FIFO_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  task automatic step(input logic iv, input logic ie, input logic [7:0] d,
                      input logic rdy, input logic clr);
    in_valid = iv; in_error = ie; in_data = d; out_ready = rdy; err_clr = clr;
    @(posedge clk);
    model_edge(iv, ie, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_error = 0; out_ready = 0; err_clr = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_rts", 32'(rts), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // single byte latency
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    chk("lat_count", 32'(count), 1);
    chk("lat_vld_early", 32'(out_valid), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_vld", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h A5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_popped", 32'(count), 0);

    // fill to full, rts from 12, overflow on 17th
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      chk("fill_rts", 32'(rts), 32'((i + 1) >= 12));
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    push_byte(8'hFF);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);

    // drain with ready held, rts hysteresis down to 4
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rts", 32'(rts), 32'((15 - i) >= 5));
    end
    chk("drain_vld", 32'(out_valid), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    chk("full_vld", 32'(out_valid), 1);
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 16);
    chk("pp_ovf", 32'(overflow), 0);
    for (int k = 0; k < 16; k++) begin
      chk("pp_order", 32'(out_data), (k < 15) ? 32'(8'h11 + 8'(k)) : 32'h55);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_empty", 32'(count), 0);

    // level-held in_valid, then errored push, then clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    chk("edge_one_push", 32'(count), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
    chk("ferr_set", 32'(frame_err), 1);
    chk("ferr_nopush", 32'(count), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ferr_clr", 32'(frame_err), 0);
    chk("ferr_data", 32'(out_data), 32'h77);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // reset with bytes buffered
    for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
    chk("pre_rst_count", 32'(count), 7);
    do_reset();
    push_byte(8'h3C);
    chk("post_rst_data", 32'(out_data), 32'h3C);
    chk("post_rst_count", 32'(count), 1);

    // randomized traffic: fill-heavy phase then drain-heavy phase
    for (int n = 0; n < 2000; n++) begin
      logic iv, ie, rdy, clr;
      logic [7:0] d;
      iv  = ($urandom_range(0, 99) < 60);
      ie  = ($urandom_range(0, 99) < 8);
      d   = 8'($urandom);
      rdy = ($urandom_range(0, 99) < ((n < 1000) ? 12 : 60));
      clr = ($urandom_range(0, 99) < 4);
      if (n == 1500) do_reset();
      step(iv, ie, d, rdy, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; power of two, 4..256.
REQ-002 Parameter AF_THRESH, default 12: count at or above which rts deasserts.
REQ-003 Parameter AE_THRESH, default 4: count at or below which rts reasserts; SHALL be < AF_THRESH.
REQ-004 Parameter IN_EDGE, default 1: 1 = push on in_valid 0->1 edge; 0 = push on every cycle in_valid is high.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  8  received byte from the UART receiver.
REQ-008 in_valid  input  1  byte-valid from receiver (level or strobe per IN_EDGE).
REQ-009 in_error  input  1  receiver framing-error flag.
REQ-010 out_data  output  8  head byte, valid while out_valid high.
REQ-011 out_valid  output  1  head byte available.
REQ-012 out_ready  input  1  consumer accepts head byte when high with out_valid.
REQ-013 rts  output  1  flow control to remote sender; low = send permitted.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky: byte dropped because FIFO full.
REQ-016 frame_err  output  1  sticky: receiver error seen.
REQ-017 err_clr  input  1  synchronous clear of overflow and frame_err.

Function
REQ-018 Push event: (IN_EDGE=1: in_valid high and previous-cycle in_valid low; IN_EDGE=0: in_valid high) and in_error low.
REQ-019 Push with in_error high SHALL NOT write; SHALL set frame_err next cycle.
REQ-020 Pop event: out_valid and out_ready both high in the same cycle.
REQ-021 Storage: circular buffer, write/read pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-022 Latency: byte pushed into empty FIFO at edge N SHALL appear on out_data with out_valid high after edge N+1; out_data stable while out_valid high and out_ready low.
REQ-023 Push when count==DEPTH and no pop: byte dropped, overflow set, count unchanged.
REQ-024 Push and pop same cycle when count==DEPTH: push accepted, count stays DEPTH, overflow unchanged.
REQ-025 Push and pop same cycle when 0<count<DEPTH: count unchanged, ordering preserved.
REQ-026 Pop when empty is impossible (out_valid low); out_ready ignored.
REQ-027 Flow FSM states RTS_ON (rts=0) and RTS_OFF (rts=1).
REQ-028 RTS_ON -> RTS_OFF when next-cycle count >= AF_THRESH; RTS_OFF -> RTS_ON when next-cycle count <= AE_THRESH; otherwise hold (hysteresis).
REQ-029 err_clr high clears overflow and frame_err; a same-cycle set event SHALL win over clear.
REQ-030 count SHALL equal pushes accepted minus pops at all times.

Reset
REQ-031 reset_n low asynchronously: pointers 0, count 0, out_valid 0, out_data 8'h00, rts 0 (RTS_ON), overflow 0, frame_err 0, edge-detect history 0, stats counter 0.
REQ-032 Reset mid-operation discards all buffered bytes; first push after release behaves as into empty FIFO.
REQ-033 Memory contents need not be reset.

Configuration
REQ-034 Macro UART_RX_FIFO_STATS_EN defined: adds output drop_count [15:0], incremented per dropped byte (REQ-023) and per errored push (REQ-019), saturating at 16'hFFFF, cleared by err_clr and reset.
REQ-035 Macro undefined: drop_count port and counter absent; all other behaviour identical.

Structure
REQ-036 Shared package uart_pkg holds flow-FSM state encoding (RTS_ON, RTS_OFF) and the UART byte width constant (8).
REQ-037 One sub-module uart_fifo_mem: DEPTH x 8 storage, one write port, one read port, no reset.

Verification
REQ-038 Push 8'hA5 into empty FIFO -> out_valid high, out_data 8'hA5 one cycle later; count 1.
REQ-039 DEPTH=16: push 16 bytes 0x00..0x0F, no pops -> rts high from count 12; 17th push 0xFF dropped, overflow 1, count 16; pops return 0x00..0x0F in order.
REQ-040 Drain from 16 with out_ready held high -> rts stays high through count 5, low at count 4; out_valid low after 16 pops.
REQ-041 Full FIFO, simultaneous push 0x55 and pop -> count 16, overflow 0, 0x55 is last byte read out.
REQ-042 in_valid held high 5 cycles with IN_EDGE=1 -> exactly one push; in_error high with in_valid edge -> no push, frame_err 1; err_clr -> frame_err 0.
REQ-043 Reset_n pulsed low with 7 bytes buffered -> count 0, out_valid 0, rts 0 immediately; next push 0x3C reads out as 0x3C.
